pid_mac_sequencer: RTL and testbench

Time-multiplexes one signed fixed-point multiplier across the five terms of the fan PID difference equation:
y[n] = b2·e[n] + b1·e[n-1] + b0·e[n-2] − a1·y[n-1] − a0·y[n-2]
- Runs one update per PID clock-enable tick.
- Holds the e/y history, saturates the result to the PWM duty range, and presents it with a valid strobe.
- Sits between the ADC/setpoint registers and the PWM generator, replacing five parallel multipliers.

---
 rtl/pid_mac_pkg.sv | 39 +++
 rtl/fx_mul_shift.sv | 22 ++
 rtl/pid_mac_sequencer.sv | 176 +++++++++++++++++
 tb/tb_pid_mac_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/pid_mac_pkg.sv
// Shared state type, default widths, MAC step indices and output clamp
// for the time-multiplexed fan PID sequencer.
package pid_mac_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        SAT  = 2'd2
    } state_t;

    localparam int DEF_REG_BITWIDTH  = 35;
    localparam int DEF_FRAC_BITWIDTH = 30;
    localparam int DEF_ERR_BITWIDTH  = 9;
    localparam int DEF_OUT_BITWIDTH  = 8;

    localparam int STEP_BITWIDTH = 3;

    localparam logic [STEP_BITWIDTH-1:0] STEP_B2 = 3'd0;
    localparam logic [STEP_BITWIDTH-1:0] STEP_B1 = 3'd1;
    localparam logic [STEP_BITWIDTH-1:0] STEP_B0 = 3'd2;
    localparam logic [STEP_BITWIDTH-1:0] STEP_A1 = 3'd3;
    localparam logic [STEP_BITWIDTH-1:0] STEP_A0 = 3'd4;

    // Clamp a signed integer part into the PWM duty range 0 .. 2^out_bits-1.
    function automatic longint sat_limit(input longint int_part, input int out_bits);
        longint max_v;
        longint result;
        max_v = (longint'(1) <<< out_bits) - longint'(1);
        if (int_part < longint'(0)) begin
            result = longint'(0);
        end else if (int_part > max_v) begin
            result = max_v;
        end else begin
            result = int_part;
        end
        return result;
    endfunction

endpackage

// File: rtl/fx_mul_shift.sv
// Single shared signed multiplier: full-width product, then arithmetic
// shift right by the fractional width (rounds toward minus infinity).
module fx_mul_shift
    import pid_mac_pkg::*;
#(
    parameter int A_BITWIDTH    = DEF_REG_BITWIDTH,
    parameter int B_BITWIDTH    = DEF_REG_BITWIDTH,
    parameter int FRAC_BITWIDTH = DEF_FRAC_BITWIDTH,
    parameter int P_BITWIDTH    = A_BITWIDTH + B_BITWIDTH - FRAC_BITWIDTH
) (
    input  logic signed [A_BITWIDTH-1:0] a,
    input  logic signed [B_BITWIDTH-1:0] b,
    output logic signed [P_BITWIDTH-1:0] p
);

    logic signed [A_BITWIDTH+B_BITWIDTH-1:0] full;

    assign full = a * b;
    // Dropped top bits are sign copies for any in-range operand pair.
    assign p    = P_BITWIDTH'(full >>> FRAC_BITWIDTH);

endmodule

// File: rtl/pid_mac_sequencer.sv
// Fan PID difference equation evaluated one term per cycle on a single
// shared multiplier, with e/y history, output clamp and valid strobe.
module pid_mac_sequencer
    import pid_mac_pkg::*;
#(
    parameter int REG_BITWIDTH  = DEF_REG_BITWIDTH,
    parameter int FRAC_BITWIDTH = DEF_FRAC_BITWIDTH,
    parameter int ERR_BITWIDTH  = DEF_ERR_BITWIDTH,
    parameter int OUT_BITWIDTH  = DEF_OUT_BITWIDTH
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start_i,
    input  logic                           clear_i,
    input  logic signed [ERR_BITWIDTH-1:0] err_i,
    input  logic signed [REG_BITWIDTH-1:0] b2_i,
    input  logic signed [REG_BITWIDTH-1:0] b1_i,
    input  logic signed [REG_BITWIDTH-1:0] b0_i,
    input  logic signed [REG_BITWIDTH-1:0] a1_i,
    input  logic signed [REG_BITWIDTH-1:0] a0_i,
    output logic        [OUT_BITWIDTH-1:0] y_o,
    output logic                           valid_o,
    output logic                           busy_o,
    output logic                           overrun_o
);

    // History words hold the full integer range of err_i and of the clamped
    // output above the binary point, so e0 and y1 never wrap.
    localparam int INT_BITWIDTH  = (ERR_BITWIDTH > OUT_BITWIDTH) ? ERR_BITWIDTH
                                                                 : OUT_BITWIDTH + 1;
    localparam int HIST_BITWIDTH = INT_BITWIDTH + FRAC_BITWIDTH;
    localparam int PROD_BITWIDTH = REG_BITWIDTH + HIST_BITWIDTH - FRAC_BITWIDTH;
    localparam int ACC_BITWIDTH  = PROD_BITWIDTH + 3;

    state_t                            state;
    state_t                            state_nxt;
    logic        [STEP_BITWIDTH-1:0]   step;

    logic signed [HIST_BITWIDTH-1:0]   e0;
    logic signed [HIST_BITWIDTH-1:0]   e1;
    logic signed [HIST_BITWIDTH-1:0]   e2;
    logic signed [HIST_BITWIDTH-1:0]   y1;
    logic signed [HIST_BITWIDTH-1:0]   y2;
    logic signed [ACC_BITWIDTH-1:0]    acc;

    logic signed [REG_BITWIDTH-1:0]    coef_sel;
    logic signed [HIST_BITWIDTH-1:0]   hist_sel;
    logic                              subtract;
    logic signed [PROD_BITWIDTH-1:0]   prod;
    logic        [OUT_BITWIDTH-1:0]    y_sat;

    // NOTE: this design resets synchronously; rst_n is sampled only on clk.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        if (clear_i) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (start_i) state_nxt = MAC;
                MAC:     if (step == STEP_A0) state_nxt = SAT;
                SAT:     state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Operand mux feeding the one multiplier; a-terms are subtracted.
    always_comb begin
        coef_sel = b2_i;
        hist_sel = e0;
        subtract = 1'b0;
        case (step)
            STEP_B1: begin
                coef_sel = b1_i;
                hist_sel = e1;
            end
            STEP_B0: begin
                coef_sel = b0_i;
                hist_sel = e2;
            end
            STEP_A1: begin
                coef_sel = a1_i;
                hist_sel = y1;
                subtract = 1'b1;
            end
            STEP_A0: begin
                coef_sel = a0_i;
                hist_sel = y2;
                subtract = 1'b1;
            end
            default: ;
        endcase
    end

    fx_mul_shift #(
        .A_BITWIDTH    (REG_BITWIDTH),
        .B_BITWIDTH    (HIST_BITWIDTH),
        .FRAC_BITWIDTH (FRAC_BITWIDTH),
        .P_BITWIDTH    (PROD_BITWIDTH)
    ) u_mul (
        .a (coef_sel),
        .b (hist_sel),
        .p (prod)
    );

    assign y_sat  = OUT_BITWIDTH'(sat_limit(longint'(acc >>> FRAC_BITWIDTH), OUT_BITWIDTH));
    assign busy_o = (state != IDLE);

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the values from before this edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            step      <= STEP_B2;
            e0        <= '0;
            e1        <= '0;
            e2        <= '0;
            y1        <= '0;
            y2        <= '0;
            acc       <= '0;
            y_o       <= '0;
            valid_o   <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            valid_o   <= 1'b0;
            overrun_o <= 1'b0;
            if (clear_i) begin
                step <= STEP_B2;
                e0   <= '0;
                e1   <= '0;
                e2   <= '0;
                y1   <= '0;
                y2   <= '0;
                acc  <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start_i) begin
                            e0   <= HIST_BITWIDTH'(err_i) <<< FRAC_BITWIDTH;
                            acc  <= '0;
                            step <= STEP_B2;
                        end
                    end
                    MAC: begin
                        overrun_o <= start_i;
                        acc  <= subtract ? acc - ACC_BITWIDTH'(prod)
                                         : acc + ACC_BITWIDTH'(prod);
                        step <= step + 3'd1;
                    end
                    SAT: begin
                        overrun_o <= start_i;
                        y_o       <= y_sat;
                        valid_o   <= 1'b1;
                        e2        <= e1;
                        e1        <= e0;
                        y2        <= y1;
                        // Feed back the clamped value so no overshoot is stored.
                        y1        <= {{(HIST_BITWIDTH - OUT_BITWIDTH){1'b0}}, y_sat}
                                     <<< FRAC_BITWIDTH;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pid_mac_sequencer.sv
// Directed bench for pid_mac_sequencer: latency, clamp, integrator with
// anti-windup, delayed taps, overrun and mid-update clear.
module tb_pid_mac_sequencer;

    localparam logic signed [34:0] ZERO    = 35'sd0;
    localparam logic signed [34:0] ONE     = 35'sd1073741824;
    localparam logic signed [34:0] TWO     = 35'sd2147483648;
    localparam logic signed [34:0] NEG_ONE = -35'sd1073741824;

    logic              clk;
    logic              rst_n;
    logic              start_i;
    logic              clear_i;
    logic signed [8:0] err_i;
    logic signed [34:0] b2, b1, b0, a1, a0;
    logic        [7:0] y_o;
    logic              valid_o;
    logic              busy_o;
    logic              overrun_o;

    int total;
    int bad;
    int vcnt;
    int lat;
    int bcnt;
    logic [7:0] y;

    pid_mac_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start_i),
        .clear_i   (clear_i),
        .err_i     (err_i),
        .b2_i      (b2),
        .b1_i      (b1),
        .b0_i      (b0),
        .a1_i      (a1),
        .a0_i      (a0),
        .y_o       (y_o),
        .valid_o   (valid_o),
        .busy_o    (busy_o),
        .overrun_o (overrun_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc_v();
        cyc();
        vcnt += int'(valid_o);
    endtask

    task automatic set_coef(input logic signed [34:0] c_b2, input logic signed [34:0] c_b1,
                            input logic signed [34:0] c_b0, input logic signed [34:0] c_a1,
                            input logic signed [34:0] c_a0);
        b2 = c_b2;
        b1 = c_b1;
        b0 = c_b0;
        a1 = c_a1;
        a0 = c_a0;
    endtask

    // Called in cycle N+1 of an accepted start; returns in the valid cycle.
    task automatic wait_valid(output int l, output int bc);
        l  = 1;
        bc = int'(busy_o);
        while (!valid_o && l < 20) begin
            cyc();
            l++;
            bc += int'(busy_o);
        end
    endtask

    task automatic do_update(input logic signed [8:0] err, output logic [7:0] yy,
                             output int l, output int bc);
        err_i   = err;
        start_i = 1'b1;
        cyc();
        start_i = 1'b0;
        wait_valid(l, bc);
        yy = y_o;
    endtask

    task automatic pulse_clear();
        clear_i = 1'b1;
        cyc();
        clear_i = 1'b0;
    endtask

    logic signed [8:0] int_err [8];
    logic        [7:0] int_exp [8];
    logic signed [8:0] tap_err [3];
    logic        [7:0] tap_exp [3];

    initial begin
        total   = 0;
        bad     = 0;
        vcnt    = 0;
        rst_n   = 1'b0;
        start_i = 1'b0;
        clear_i = 1'b0;
        err_i   = '0;
        set_coef(ZERO, ZERO, ZERO, ZERO, ZERO);
        int_err = '{9'sd10, 9'sd10, 9'sd10, 9'sd100, 9'sd100, 9'sd100, 9'sd100, -9'sd10};
        int_exp = '{8'd10, 8'd20, 8'd30, 8'd130, 8'd230, 8'd255, 8'd255, 8'd245};
        tap_err = '{9'sd7, 9'sd0, 9'sd0};
        tap_exp = '{8'd0, 8'd0, 8'd7};

        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        check("rst_y", 64'(y_o), 64'(0));
        check("rst_valid", 64'(valid_o), 64'(0));
        check("rst_busy", 64'(busy_o), 64'(0));
        check("rst_overrun", 64'(overrun_o), 64'(0));

        // Pass-through gain of one.
        set_coef(ONE, ZERO, ZERO, ZERO, ZERO);
        do_update(9'sd20, y, lat, bcnt);
        check("basic_latency", 64'(lat), 64'(7));
        check("basic_y", 64'(y), 64'(20));
        check("basic_busy_cycles", 64'(bcnt), 64'(6));
        cyc();
        check("basic_valid_one_cycle", 64'(valid_o), 64'(0));

        // Clamp at both ends.
        do_update(-9'sd5, y, lat, bcnt);
        check("sat_low_y", 64'(y), 64'(0));
        set_coef(TWO, ZERO, ZERO, ZERO, ZERO);
        do_update(9'sd200, y, lat, bcnt);
        check("sat_high_y", 64'(y), 64'(255));

        pulse_clear();
        check("clear_idle_keeps_y", 64'(y_o), 64'(255));
        check("clear_idle_busy", 64'(busy_o), 64'(0));

        // Integrator y[n] = e[n] + y[n-1], with windup held at the clamp.
        set_coef(ONE, ZERO, ZERO, NEG_ONE, ZERO);
        for (int i = 0; i < 8; i++) begin
            do_update(int_err[i], y, lat, bcnt);
            check($sformatf("integ_y%0d", i), 64'(y), 64'(int_exp[i]));
            repeat (93) cyc();
        end

        // Two-sample delay tap.
        pulse_clear();
        set_coef(ZERO, ZERO, ONE, ZERO, ZERO);
        for (int i = 0; i < 3; i++) begin
            do_update(tap_err[i], y, lat, bcnt);
            check($sformatf("tap_y%0d", i), 64'(y), 64'(tap_exp[i]));
        end

        // Overrun: second start at N+3 dropped, start at N+7 accepted.
        pulse_clear();
        set_coef(ONE, ZERO, ZERO, ZERO, ZERO);
        err_i   = 9'sd20;
        vcnt    = 0;
        start_i = 1'b1;
        cyc();
        start_i = 1'b0;
        vcnt += int'(valid_o);
        cyc_v();
        cyc_v();
        start_i = 1'b1;
        cyc_v();
        start_i = 1'b0;
        check("ovr_pulse_n4", 64'(overrun_o), 64'(1));
        cyc_v();
        check("ovr_pulse_n5_low", 64'(overrun_o), 64'(0));
        cyc_v();
        cyc_v();
        check("ovr_valid_n7", 64'(valid_o), 64'(1));
        check("ovr_y", 64'(y_o), 64'(20));
        check("ovr_valid_count", 64'(vcnt), 64'(1));
        start_i = 1'b1;
        cyc();
        start_i = 1'b0;
        check("ovr_accept_n7_busy", 64'(busy_o), 64'(1));
        check("ovr_accept_n7_no_overrun", 64'(overrun_o), 64'(0));
        wait_valid(lat, bcnt);
        check("ovr_second_latency", 64'(lat), 64'(7));

        // Clear in cycle N+4 aborts the update and wipes history.
        set_coef(ONE, ZERO, ZERO, NEG_ONE, ZERO);
        err_i   = 9'sd50;
        start_i = 1'b1;
        cyc();
        start_i = 1'b0;
        cyc();
        cyc();
        cyc();
        clear_i = 1'b1;
        cyc();
        clear_i = 1'b0;
        check("clr_busy_n5", 64'(busy_o), 64'(0));
        vcnt = 0;
        repeat (10) cyc_v();
        check("clr_no_valid", 64'(vcnt), 64'(0));
        check("clr_keeps_y", 64'(y_o), 64'(20));
        do_update(9'sd10, y, lat, bcnt);
        check("clr_history_zero_y", 64'(y), 64'(10));
        check("clr_next_latency", 64'(lat), 64'(7));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
